game_sequencer: RTL and testbench

Frame-paced game-flow controller for the goal/paddle display game. It sits between the push-buttons, the collision flags from the display/object logic, and that logic's motion enables. It sequences idle, serve, play, pause, goal, miss and game-over phases, and keeps score and lives. Outputs gate object motion (`play_en`), recentre the ball (`ball_serve`), and drive score/status overlays (`flash`, `game_over`).

---
 rtl/game_sequencer.sv | 138 +++++++++++++
 tb/tb_game_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frame-paced game-flow controller: serve/play/pause/goal/miss/over, score and lives
module game_sequencer #(
    parameter int WIN_SCORE    = 5,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int EVENT_FRAMES = 90,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       refresh_tick,
    input  logic       btn_start,
    input  logic       goal_hit,
    input  logic       ball_miss,
    output logic       play_en,
    output logic       ball_serve,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       flash,
    output logic       game_over
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_GOAL  = 3'd4;
    localparam logic [2:0] S_MISS  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    // Terminal counts are matched on the frame that would bring the count to the limit.
    localparam logic [7:0] SERVE_T = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] EVENT_T = 8'(EVENT_FRAMES - 1);
    localparam logic [7:0] FLASH_T = 8'(FLASH_FRAMES - 1);
    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [1:0] LIVES_R = 2'(LIVES);

    logic       tick_q, btn_q;
    logic       frame, start, changing;
    logic [2:0] state_nx;
    logic [7:0] cnt, cnt_nx, fcnt, fcnt_nx;
    logic [3:0] score_nx;
    logic [1:0] lives_nx;
    logic       flash_nx, play_en_nx, ball_serve_nx, game_over_nx;

    assign frame    = refresh_tick & ~tick_q;
    assign start    = btn_start & ~btn_q;
    assign changing = (state_nx != state);

    function automatic logic is_flash_state(input logic [2:0] s);
        return (s == S_GOAL) || (s == S_MISS) || (s == S_OVER);
    endfunction

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= 1'b0;
            btn_q      <= 1'b1;
            state      <= S_IDLE;
            cnt        <= 8'd0;
            fcnt       <= 8'd0;
            score      <= 4'd0;
            lives      <= LIVES_R;
            flash      <= 1'b0;
            play_en    <= 1'b0;
            ball_serve <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            tick_q     <= refresh_tick;
            btn_q      <= btn_start;
            state      <= state_nx;
            cnt        <= cnt_nx;
            fcnt       <= fcnt_nx;
            score      <= score_nx;
            lives      <= lives_nx;
            flash      <= flash_nx;
            play_en    <= play_en_nx;
            ball_serve <= ball_serve_nx;
            game_over  <= game_over_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SERVE;
            S_SERVE: if (frame && cnt == SERVE_T) state_nx = S_PLAY;
            S_PLAY: begin
                if (goal_hit)       state_nx = S_GOAL;
                else if (ball_miss) state_nx = S_MISS;
                else if (start)     state_nx = S_PAUSE;
            end
            S_PAUSE: if (start) state_nx = S_PLAY;
            S_GOAL:  if (frame && cnt == EVENT_T) state_nx = (score == WIN_S) ? S_OVER : S_SERVE;
            S_MISS:  if (frame && cnt == EVENT_T) state_nx = (lives == 2'd0) ? S_OVER : S_SERVE;
            S_OVER:  if (start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nx        = cnt;
        fcnt_nx       = fcnt;
        flash_nx      = flash;
        score_nx      = score;
        lives_nx      = lives;
        play_en_nx    = (state_nx == S_PLAY);
        ball_serve_nx = changing && (state_nx == S_SERVE);
        game_over_nx  = (state_nx == S_OVER);

        if (changing)
            cnt_nx = 8'd0;
        else if (frame && cnt != 8'hFF)
            cnt_nx = cnt + 8'd1;

        if (changing) begin
            fcnt_nx  = 8'd0;
            flash_nx = is_flash_state(state_nx);
        end else if (!is_flash_state(state)) begin
            flash_nx = 1'b0;
        end else if (frame) begin
            if (fcnt == FLASH_T) begin
                fcnt_nx  = 8'd0;
                flash_nx = ~flash;
            end else begin
                fcnt_nx = fcnt + 8'd1;
            end
        end

        if (changing && state_nx == S_GOAL && score != 4'hF)
            score_nx = score + 4'd1;
        if (changing && state_nx == S_MISS && lives != 2'd0)
            lives_nx = lives - 2'd1;
        if (state == S_OVER && state_nx == S_IDLE) begin
            score_nx = 4'd0;
            lives_nx = LIVES_R;
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
    logic       clk_100MHz = 1'b0;
    logic       rst_n, refresh_tick, btn_start, goal_hit, ball_miss;
    logic       play_en, ball_serve, flash, game_over;
    logic [3:0] score;
    logic [1:0] lives;
    logic [2:0] state;
    int         n_checks = 0;
    int         n_fail   = 0;

    game_sequencer dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .refresh_tick(refresh_tick),
        .btn_start   (btn_start),
        .goal_hit    (goal_hit),
        .ball_miss   (ball_miss),
        .play_en     (play_en),
        .ball_serve  (ball_serve),
        .score       (score),
        .lives       (lives),
        .state       (state),
        .flash       (flash),
        .game_over   (game_over)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press();
        btn_start = 1'b1;
        @(negedge clk_100MHz);
        btn_start = 1'b0;
        @(negedge clk_100MHz);
    endtask

    task automatic frames(input int n, input int w);
        for (int k = 0; k < n; k++) begin
            refresh_tick = 1'b1;
            repeat (w) @(negedge clk_100MHz);
            refresh_tick = 1'b0;
            @(negedge clk_100MHz);
        end
    endtask

    initial begin
        rst_n = 1'b0; refresh_tick = 1'b0; btn_start = 1'b1; goal_hit = 1'b0; ball_miss = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_play_en", play_en, 0);
        check("rst_ball_serve", ball_serve, 0);
        check("rst_flash", flash, 0);
        check("rst_game_over", game_over, 0);
        btn_start = 1'b0;
        @(negedge clk_100MHz);

        // serve timing with 4-clock tick pulses
        btn_start = 1'b1;
        @(negedge clk_100MHz);
        btn_start = 1'b0;
        check("serve_state", state, 1);
        check("serve_pulse", ball_serve, 1);
        @(negedge clk_100MHz);
        check("serve_pulse_end", ball_serve, 0);
        frames(59, 4);
        check("serve_59_state", state, 1);
        check("serve_59_play_en", play_en, 0);
        refresh_tick = 1'b1;
        @(negedge clk_100MHz);
        check("serve_60_state", state, 2);
        check("serve_60_play_en", play_en, 1);
        repeat (3) @(negedge clk_100MHz);
        refresh_tick = 1'b0;
        @(negedge clk_100MHz);

        // goal and miss together: goal wins, counted once
        goal_hit = 1'b1; ball_miss = 1'b1;
        @(negedge clk_100MHz);
        check("both_state", state, 4);
        check("both_score", score, 1);
        check("both_lives", lives, 3);
        check("both_flash", flash, 1);
        check("both_play_en", play_en, 0);
        repeat (19) @(negedge clk_100MHz);
        goal_hit = 1'b0; ball_miss = 1'b0;
        check("hold_score", score, 1);
        check("hold_state", state, 4);
        frames(7, 2);
        check("flash_7", flash, 1);
        frames(1, 2);
        check("flash_8", flash, 0);
        frames(81, 2);
        check("goal_89_state", state, 4);
        frames(1, 2);
        check("goal_90_state", state, 1);
        check("goal_90_flash", flash, 0);

        // three misses to game over
        for (int i = 1; i <= 3; i++) begin
            frames(60, 1);
            check("miss_play", state, 2);
            ball_miss = 1'b1;
            @(negedge clk_100MHz);
            ball_miss = 1'b0;
            check("miss_state", state, 5);
            check("miss_lives", lives, 3 - i);
            frames(90, 1);
            check("miss_exit", state, (i < 3) ? 1 : 6);
        end
        check("over_game_over", game_over, 1);
        check("over_flash", flash, 1);
        press();
        check("restart_state", state, 0);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        check("restart_game_over", game_over, 0);

        // five goals to win; start in SERVE is ignored
        press();
        check("win_serve", state, 1);
        press();
        check("serve_start_ignored", state, 1);
        for (int i = 1; i <= 5; i++) begin
            frames(60, 1);
            check("win_play", state, 2);
            goal_hit = 1'b1;
            @(negedge clk_100MHz);
            goal_hit = 1'b0;
            check("win_score", score, i);
            frames(90, 1);
            check("win_exit", state, (i < 5) ? 1 : 6);
        end
        check("win_game_over", game_over, 1);
        press();
        check("win_restart", state, 0);

        // pause, ignored goal, resume, async reset
        press();
        frames(60, 1);
        press();
        check("pause_state", state, 3);
        check("pause_play_en", play_en, 0);
        goal_hit = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        goal_hit = 1'b0;
        check("pause_goal_state", state, 3);
        check("pause_goal_score", score, 0);
        press();
        check("resume_state", state, 2);
        check("resume_play_en", play_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_play_en", play_en, 0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        check("post_rst_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
